// File: rtl/register_bank_if.sv
// Request/response bundle for register_bank: one write port, two read ports,
// and the bulk-clear handshake.
interface register_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic              rd_valid_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_valid_b;
  logic              clr_req;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy
  );
endinterface

// File: rtl/register_bank.sv
// NUM_REGS x WIDTH register bank: one write port, two registered read ports,
// sequenced bulk clear. Define REGISTER_BANK_WRITE_BYPASS_EN for write-to-read bypass.
module rb_rd_port #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                              clock,
  input  logic                              aresetn,
  input  logic                              accept,
  input  logic [ADDR_W-1:0]                 rd_addr,
  input  logic [NUM_REGS-1:0][WIDTH-1:0]    mem,
  input  logic                              fwd_hit,
  input  logic [WIDTH-1:0]                  fwd_data,
  output logic [WIDTH-1:0]                  rd_data,
  output logic                              rd_valid
);
  logic [WIDTH-1:0] rsel;

  // Addresses past NUM_REGS match no entry and read as zero.
  always_comb begin
    rsel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == i[ADDR_W-1:0]) rsel = mem[i];
    if (fwd_hit) rsel = fwd_data;
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept;
      if (accept) rd_data <= rsel;
    end
  end
endmodule

module register_bank #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic           clock,
  input  logic           aresetn,
  register_bank_if.slave bus
);
  localparam int NPORT = 2;
  localparam logic [ADDR_W:0]   NREG = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS-1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                       state;
  logic [ADDR_W-1:0]            cnt;
  logic [NUM_REGS-1:0][WIDTH-1:0] mem;
  logic                         idle, wr_ok, in_rng, zero_hit;

  logic [NPORT-1:0]             rd_en, rd_valid, fwd_hit;
  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][WIDTH-1:0]  rd_data;

  assign idle     = (state == IDLE);
  assign in_rng   = ({1'b0, bus.wr_addr} < NREG);
  assign zero_hit = (ZERO_REG != 0) && (bus.wr_addr == '0);
  // A clear request in the same cycle takes priority over the write.
  assign wr_ok    = idle && bus.wr_en && !bus.clr_req && in_rng && !zero_hit;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.clr_req) begin
          state    <= CLEAR;
          cnt      <= '0;
          bus.busy <= 1'b1;
        end
        CLEAR: if (cnt == LAST) begin
          state    <= IDLE;
          cnt      <= '0;
          bus.busy <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      mem <= '0;
    end else begin
      for (int e = 0; e < NUM_REGS; e++) begin
        if (!idle && cnt == e[ADDR_W-1:0])            mem[e] <= '0;
        else if (wr_ok && bus.wr_addr == e[ADDR_W-1:0]) mem[e] <= bus.wr_data;
      end
    end
  end

  assign rd_en   = {bus.rd_en_b,   bus.rd_en_a};
  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  for (genvar g = 0; g < NPORT; g++) begin : g_port
`ifdef REGISTER_BANK_WRITE_BYPASS_EN
    assign fwd_hit[g] = wr_ok && (bus.wr_addr == rd_addr[g]);
`else
    assign fwd_hit[g] = 1'b0;
`endif
    rb_rd_port #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_port (
      .clock    (clock),
      .aresetn  (aresetn),
      .accept   (idle && rd_en[g]),
      .rd_addr  (rd_addr[g]),
      .mem      (mem),
      .fwd_hit  (fwd_hit[g]),
      .fwd_data (bus.wr_data),
      .rd_data  (rd_data[g]),
      .rd_valid (rd_valid[g])
    );
  end

  assign bus.rd_data_a  = rd_data[0];
  assign bus.rd_valid_a = rd_valid[0];
  assign bus.rd_data_b  = rd_data[1];
  assign bus.rd_valid_b = rd_valid[1];
endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised multi-entry register bank for the RISC CPU datapath.
- Successor to the single parallel-load register: NUM_REGS entries of WIDTH bits, one write port, two registered read ports.
- Adds a sequenced bulk-clear engine, an optional hardwired-zero entry, and optional write-to-read bypass.
- Sits between the decode stage, which supplies read addresses, and the writeback stage, which supplies writes.

Parameters:
- WIDTH, 8, data width of each entry in bits.
- NUM_REGS, 8, number of entries (≥2; need not be a power of two).
- ADDR_W, $clog2(NUM_REGS), address width.
- ZERO_REG, 0: 1 hardwires entry 0 to all-zero (writes ignored, reads return 0); 0 makes entry 0 an ordinary entry.

Ports:
- clock  in  1  rising-edge clock.
- aresetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_en_a  in  1  read request, port A.
- rd_addr_a  in  ADDR_W  read address, port A.
- rd_data_a  out  WIDTH  registered read data, port A.
- rd_valid_a  out  1  rd_data_a updated this cycle.
- rd_en_b  in  1  read request, port B.
- rd_addr_b  in  ADDR_W  read address, port B.
- rd_data_b  out  WIDTH  registered read data, port B.
- rd_valid_b  out  1  rd_data_b updated this cycle.
- clr_req  in  1  single-cycle pulse requesting a bulk clear of all entries.
- busy  out  1  bulk clear in progress.

Behaviour:
- Reset (aresetn low, asynchronous): all entries 0; rd_data_a/b = 0; rd_valid_a/b = 0; busy = 0; FSM = IDLE; clear counter = 0.
- Write: wr_en high in IDLE at edge → mem[wr_addr] <= wr_data. Visible to reads issued the following cycle.
- Write ignored when:
  - wr_addr ≥ NUM_REGS;
  - ZERO_REG=1 and wr_addr=0.
- Read, 1-cycle latency:
  - rd_en_x high in IDLE at edge N → rd_data_x = mem[rd_addr_x] and rd_valid_x = 1 after edge N.
  - rd_valid_x is a one-cycle pulse per accepted request.
  - rd_data_x holds its last value when no read is accepted.
  - Out-of-range address returns 0 with rd_valid_x = 1.
- Ports A and B are fully independent; both may read the same address in the same cycle.
- Read/write same address, same cycle (no bypass): read returns the old content.
- FSM states:
  - IDLE: normal operation. clr_req → CLEAR with counter = 0 and busy = 1 from the next cycle.
  - CLEAR: each cycle mem[counter] <= 0 and counter++. When counter = NUM_REGS-1 the entry is cleared, FSM → IDLE and busy = 0 next cycle. A clear therefore takes exactly NUM_REGS cycles.
- During CLEAR:
  - wr_en is dropped;
  - rd_en_a/b are ignored (rd_valid stays 0, rd_data holds);
  - clr_req is ignored.
- clr_req and wr_en in the same IDLE cycle: clear wins and the write is dropped. Reads in that cycle are still accepted.
- Reset mid-CLEAR: immediate return to IDLE with all entries 0.

Optional Feature:
- Macro: REGISTER_BANK_WRITE_BYPASS_EN.
- Defined: a read of address X in the same cycle as an accepted write to X returns wr_data, independently per port. No bypass applies when the write is dropped (CLEAR, out of range, or ZERO_REG entry 0).
- Undefined: same-cycle read returns the old content. Latency is 1 cycle in both cases.

Test Plan:
- Reset, then read A=3 and B=7 → rd_valid_a/b = 1 next cycle, data 0x00 on both.
- Write 0xA5 to 2, next cycle read A=2 and B=2 → both return 0xA5 one cycle later, valid pulses are one cycle wide.
- Write 0x3C to 5 while reading A=5 in the same cycle:
  - without macro → 0x00;
  - with REGISTER_BANK_WRITE_BYPASS_EN → 0x3C.
- Fill entries 0..7 with 0x11..0x88, pulse clr_req:
  - busy high for exactly 8 cycles;
  - a write of 0xFF to 1 mid-clear is dropped;
  - a read mid-clear gives no rd_valid;
  - after busy falls, reads of all entries return 0x00.
- ZERO_REG=1: write 0x77 to 0, read 0 → 0x00. NUM_REGS=6: write to 6/7 is ignored; read 7 → 0x00 with valid.
- Assert aresetn low at the 3rd cycle of CLEAR → busy = 0 and rd_valid = 0 immediately. After release, a read of any entry returns 0x00 and a new write/read works.
